spram_rr_arbiter: RTL and testbench
===================================

Name: spram_rr_arbiter

Overview:
- Shares one single-port RAM between two independent requesters (N = 0, 1), each with a valid/ready command channel and a response channel.
- Uses round-robin arbitration and accepts at most one command per cycle.
- Registers the RAM command and routes read data back to the originating requester using a tag pipeline.
- Sits between the top-level logic and the single-port RAM; it is the only driver of the RAM ports.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, cycles from RAM command (en=1, we=0) to valid in_ram_rdata; legal range 1..4.

Ports:
- in_clk  input  1  clock; all logic on rising edge.
- in_rst  input  1  synchronous active-high reset.
- in_reqN_valid  input  1  requester N presents a command (N = 0, 1; same for all reqN/rspN lines below).
- out_reqN_ready  output  1  command from requester N accepted this cycle.
- in_reqN_we  input  1  1 = write, 0 = read.
- in_reqN_addr  input  ADDR_W  command address.
- in_reqN_wdata  input  DATA_W  write data; ignored for reads.
- out_rspN_valid  output  1  one-cycle pulse; out_rspN_rdata is valid.
- out_rspN_rdata  output  DATA_W  read data for requester N.
- out_ram_en  output  1  RAM access enable.
- out_ram_we  output  1  RAM write enable.
- out_ram_addr  output  ADDR_W  RAM address.
- out_ram_wdata  output  DATA_W  RAM write data.
- in_ram_rdata  input  DATA_W  RAM read data.

Behaviour:
- Arbitration (combinational from the current valids and the registered pointer last_grant):
  - Only one valid: that requester wins.
  - Both valid: the requester other than last_grant wins.
  - out_reqN_ready = winner==N, and never high during in_rst.
  - The transfer happens on valid & ready.
- Pointer:
  - last_grant updates to the winner on every accepted command; otherwise it holds.
  - Reset value is 1, so requester 0 wins the first contention.
- Fairness: two continuously valid requesters alternate grants exactly (0,1,0,1,...). Neither waits more than 1 cycle.
- Throughput and command registration:
  - Throughput is one command per cycle.
  - A command accepted in cycle T drives out_ram_en=1, out_ram_we, out_ram_addr and out_ram_wdata during cycle T+1, all from registers.
  - With no acceptance in T, out_ram_en=0 and out_ram_we=0 in T+1; addr and wdata hold their last values.
- Tag pipeline:
  - A shift register of depth RD_LAT+1 carries {is_read, requester_id}.
  - It is loaded at acceptance and advances every cycle.
- Read response:
  - A read accepted in T is sampled from in_ram_rdata at the end of cycle T+1+RD_LAT.
  - It is presented registered: out_rspN_valid=1 and out_rspN_rdata during cycle T+2+RD_LAT, only for N = originating requester.
  - Total read latency from acceptance is RD_LAT+2 (3 at default).
- Writes produce no response.
- Back-to-back reads from mixed requesters return in acceptance order, one per cycle, each on its own channel.
- Response data holding: out_rspN_rdata holds its last value when out_rspN_valid=0.
- Reads and writes to the same address:
  - No forwarding is performed.
  - A read accepted the cycle after a write to the same address returns the newly written data, because the RAM sees the commands in order.
- Reset values: all outputs 0; last_grant=1; tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded and no out_rspN_valid pulse follows. Operation resumes in the first cycle with in_rst=0.
- Requester contract: a requester must hold its valid, we, addr and wdata stable until ready. A deasserted valid withdraws the request without side effects.

Test Plan:
- Reset then single write: req0 write addr 0x10 data 0xA5 -> in the next cycle ram_en=1, we=1, addr=0x10, wdata=0xA5; no rsp pulses.
- Single read after that write: req1 read addr 0x10 accepted at T -> out_rsp1_valid=1 with rdata=0xA5 at T+3; out_rsp0_valid stays 0.
- Contention: both valid continuously with reads at addrs 0..7 (preloaded data = addr+0x40) -> ready alternates 0,1,0,1; each requester gets its own 0x40+addr responses in order, one per cycle after the pipeline fills.
- Reset pointer: both valid in the first cycle after reset -> req0 granted first.
- Reset mid-flight: reads accepted at T and T+1, then in_rst high at T+2 for 1 cycle -> no rsp pulses; all outputs 0 during reset.
- RD_LAT=3 build: a read at T returns at T+5 with correct data and tag.

Source files
------------

// File: rtl/spram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port RAM.
// Ports: clk/rst, two valid/ready command channels (we/addr/wdata),
// two response channels (valid pulse + rdata), and the RAM port pair.
module spram_rr_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_req0_valid,
    output logic              out_req0_ready,
    input  logic              in_req0_we,
    input  logic [ADDR_W-1:0] in_req0_addr,
    input  logic [DATA_W-1:0] in_req0_wdata,
    output logic              out_rsp0_valid,
    output logic [DATA_W-1:0] out_rsp0_rdata,
    input  logic              in_req1_valid,
    output logic              out_req1_ready,
    input  logic              in_req1_we,
    input  logic [ADDR_W-1:0] in_req1_addr,
    input  logic [DATA_W-1:0] in_req1_wdata,
    output logic              out_rsp1_valid,
    output logic [DATA_W-1:0] out_rsp1_rdata,
    output logic              out_ram_en,
    output logic              out_ram_we,
    output logic [ADDR_W-1:0] out_ram_addr,
    output logic [DATA_W-1:0] out_ram_wdata,
    input  logic [DATA_W-1:0] in_ram_rdata
);

    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              sel_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    // Stage k holds the tag of the command issued to the RAM k cycles ago;
    // the last stage lines up with the cycle its read data is on the bus.
    logic [RD_LAT:0]   tag_rd;
    logic [RD_LAT:0]   tag_id;

    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_rdata_q;
    logic [DATA_W-1:0] rsp1_rdata_q;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!in_rst) begin
            grant0 = in_req0_valid && (!in_req1_valid || last_grant);
            grant1 = in_req1_valid && (!in_req0_valid || !last_grant);
        end
    end

    assign accept    = grant0 | grant1;
    assign sel_id    = grant1;
    assign sel_we    = grant1 ? in_req1_we    : in_req0_we;
    assign sel_addr  = grant1 ? in_req1_addr  : in_req0_addr;
    assign sel_wdata = grant1 ? in_req1_wdata : in_req0_wdata;

    assign out_req0_ready = grant0;
    assign out_req1_ready = grant1;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            last_grant   <= 1'b1;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            tag_rd       <= '0;
            tag_id       <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            if (accept) begin
                last_grant  <= sel_id;
                ram_addr_q  <= sel_addr;
                ram_wdata_q <= sel_wdata;
            end
            ram_en_q <= accept;
            ram_we_q <= accept && sel_we;
            tag_rd   <= {tag_rd[RD_LAT-1:0], accept && !sel_we};
            tag_id   <= {tag_id[RD_LAT-1:0], sel_id};

            rsp0_valid_q <= tag_rd[RD_LAT] && !tag_id[RD_LAT];
            rsp1_valid_q <= tag_rd[RD_LAT] && tag_id[RD_LAT];
            if (tag_rd[RD_LAT] && !tag_id[RD_LAT]) begin
                rsp0_rdata_q <= in_ram_rdata;
            end
            if (tag_rd[RD_LAT] && tag_id[RD_LAT]) begin
                rsp1_rdata_q <= in_ram_rdata;
            end
        end
    end

    // Outputs are forced low while reset is held, including the first
    // reset cycle before the registers have been cleared.
    assign out_ram_en     = ram_en_q && !in_rst;
    assign out_ram_we     = ram_we_q && !in_rst;
    assign out_ram_addr   = in_rst ? '0 : ram_addr_q;
    assign out_ram_wdata  = in_rst ? '0 : ram_wdata_q;
    assign out_rsp0_valid = rsp0_valid_q && !in_rst;
    assign out_rsp1_valid = rsp1_valid_q && !in_rst;
    assign out_rsp0_rdata = in_rst ? '0 : rsp0_rdata_q;
    assign out_rsp1_rdata = in_rst ? '0 : rsp1_rdata_q;

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Bench for spram_rr_arbiter: one instance at RD_LAT=1 and one at RD_LAT=3
// share the stimulus; a transaction-level model predicts every output.
module tb_spram_rr_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic       in_clk = 1'b0;
    logic       in_rst;
    logic       in_req0_valid, in_req0_we, in_req1_valid, in_req1_we;
    logic [7:0] in_req0_addr, in_req0_wdata, in_req1_addr, in_req1_wdata;

    logic       out_req0_ready_a, out_req1_ready_a;
    logic       out_rsp0_valid_a, out_rsp1_valid_a;
    logic [7:0] out_rsp0_rdata_a, out_rsp1_rdata_a;
    logic       out_ram_en_a, out_ram_we_a;
    logic [7:0] out_ram_addr_a, out_ram_wdata_a, in_ram_rdata_a;

    logic       out_req0_ready_b, out_req1_ready_b;
    logic       out_rsp0_valid_b, out_rsp1_valid_b;
    logic [7:0] out_rsp0_rdata_b, out_rsp1_rdata_b;
    logic       out_ram_en_b, out_ram_we_b;
    logic [7:0] out_ram_addr_b, out_ram_wdata_b, in_ram_rdata_b;

    int checks = 0;
    int failures = 0;

    always #5 in_clk = ~in_clk;

    spram_rr_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(LAT_A)) dut_a (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_req0_valid(in_req0_valid), .out_req0_ready(out_req0_ready_a),
        .in_req0_we(in_req0_we), .in_req0_addr(in_req0_addr),
        .in_req0_wdata(in_req0_wdata),
        .out_rsp0_valid(out_rsp0_valid_a), .out_rsp0_rdata(out_rsp0_rdata_a),
        .in_req1_valid(in_req1_valid), .out_req1_ready(out_req1_ready_a),
        .in_req1_we(in_req1_we), .in_req1_addr(in_req1_addr),
        .in_req1_wdata(in_req1_wdata),
        .out_rsp1_valid(out_rsp1_valid_a), .out_rsp1_rdata(out_rsp1_rdata_a),
        .out_ram_en(out_ram_en_a), .out_ram_we(out_ram_we_a),
        .out_ram_addr(out_ram_addr_a), .out_ram_wdata(out_ram_wdata_a),
        .in_ram_rdata(in_ram_rdata_a)
    );

    spram_rr_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(LAT_B)) dut_b (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_req0_valid(in_req0_valid), .out_req0_ready(out_req0_ready_b),
        .in_req0_we(in_req0_we), .in_req0_addr(in_req0_addr),
        .in_req0_wdata(in_req0_wdata),
        .out_rsp0_valid(out_rsp0_valid_b), .out_rsp0_rdata(out_rsp0_rdata_b),
        .in_req1_valid(in_req1_valid), .out_req1_ready(out_req1_ready_b),
        .in_req1_we(in_req1_we), .in_req1_addr(in_req1_addr),
        .in_req1_wdata(in_req1_wdata),
        .out_rsp1_valid(out_rsp1_valid_b), .out_rsp1_rdata(out_rsp1_rdata_b),
        .out_ram_en(out_ram_en_b), .out_ram_we(out_ram_we_b),
        .out_ram_addr(out_ram_addr_b), .out_ram_wdata(out_ram_wdata_b),
        .in_ram_rdata(in_ram_rdata_b)
    );

    // Behavioural RAMs: preloaded with addr+0x40, fixed read latency.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] pipe_a;
    logic [7:0] pipe_b [3];
    logic       loaded = 1'b0;

    always @(posedge in_clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'(i + 64);
                mem_b[i] <= 8'(i + 64);
            end
            loaded <= 1'b1;
        end else begin
            if (out_ram_en_a && out_ram_we_a) mem_a[out_ram_addr_a] <= out_ram_wdata_a;
            if (out_ram_en_b && out_ram_we_b) mem_b[out_ram_addr_b] <= out_ram_wdata_b;
            pipe_a <= (out_ram_en_a && !out_ram_we_a) ? mem_a[out_ram_addr_a] : 8'hEE;
            pipe_b[0] <= (out_ram_en_b && !out_ram_we_b) ? mem_b[out_ram_addr_b] : 8'hEE;
            pipe_b[1] <= pipe_b[0];
            pipe_b[2] <= pipe_b[1];
        end
    end

    assign in_ram_rdata_a = pipe_a;
    assign in_ram_rdata_b = pipe_b[2];

    // Transaction-level reference: expectations keyed by cycle number.
    int         cyc = 0;
    int         last_win = 1;
    int         exp_win = -1;
    logic [7:0] ref_mem [256];
    bit         exp_en [int];
    logic       exp_we [int];
    logic [7:0] exp_addr [int];
    logic [7:0] exp_wd [int];
    logic [7:0] exp_r0a [int];
    logic [7:0] exp_r1a [int];
    logic [7:0] exp_r0b [int];
    logic [7:0] exp_r1b [int];
    logic [7:0] hold0a = 0, hold1a = 0, hold0b = 0, hold1b = 0;
    logic       r0a, r1a, r0b, r1b;

    task automatic clear_model();
        exp_en.delete(); exp_we.delete(); exp_addr.delete(); exp_wd.delete();
        exp_r0a.delete(); exp_r1a.delete(); exp_r0b.delete(); exp_r1b.delete();
        hold0a = 0; hold1a = 0; hold0b = 0; hold1b = 0;
        last_win = 1;
    endtask

    // Drive one cycle of requests, predict the winner and its effects,
    // then move to the next cycle (sampling point is 1 time unit past the edge).
    task automatic step(input logic v0, w0, input logic [7:0] a0, d0,
                        input logic v1, w1, input logic [7:0] a1, d1);
        logic       w;
        logic [7:0] a, d;
        in_req0_valid = v0; in_req0_we = w0; in_req0_addr = a0; in_req0_wdata = d0;
        in_req1_valid = v1; in_req1_we = w1; in_req1_addr = a1; in_req1_wdata = d1;
        #1;
        r0a = out_req0_ready_a; r1a = out_req1_ready_a;
        r0b = out_req0_ready_b; r1b = out_req1_ready_b;
        exp_win = -1;
        if (v0 && !v1) exp_win = 0;
        else if (v1 && !v0) exp_win = 1;
        else if (v0 && v1) exp_win = 1 - last_win;
        if (exp_win >= 0) begin
            w = (exp_win == 1) ? w1 : w0;
            a = (exp_win == 1) ? a1 : a0;
            d = (exp_win == 1) ? d1 : d0;
            last_win = exp_win;
            exp_en[cyc+1] = 1'b1; exp_we[cyc+1] = w;
            exp_addr[cyc+1] = a; exp_wd[cyc+1] = d;
            if (w) ref_mem[a] = d;
            else if (exp_win == 0) begin
                exp_r0a[cyc+2+LAT_A] = ref_mem[a]; exp_r0b[cyc+2+LAT_B] = ref_mem[a];
            end else begin
                exp_r1a[cyc+2+LAT_A] = ref_mem[a]; exp_r1b[cyc+2+LAT_B] = ref_mem[a];
            end
        end
        @(posedge in_clk); #1;
        cyc++;
        if (exp_r0a.exists(cyc)) hold0a = exp_r0a[cyc];
        if (exp_r1a.exists(cyc)) hold1a = exp_r1a[cyc];
        if (exp_r0b.exists(cyc)) hold0b = exp_r0b[cyc];
        if (exp_r1b.exists(cyc)) hold1b = exp_r1b[cyc];
    endtask

    task automatic idle();
        step(0, 0, 8'h0, 8'h0, 0, 0, 8'h0, 8'h0);
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        in_req0_valid = 0; in_req1_valid = 0;
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        clear_model();
        cyc++;
    endtask

    function automatic logic [75:0] all_outputs();
        return {out_req0_ready_a, out_req1_ready_a, out_rsp0_valid_a, out_rsp0_rdata_a,
                out_rsp1_valid_a, out_rsp1_rdata_a, out_ram_en_a, out_ram_we_a,
                out_ram_addr_a, out_ram_wdata_a,
                out_req0_ready_b, out_req1_ready_b, out_rsp0_valid_b, out_rsp0_rdata_b,
                out_rsp1_valid_b, out_rsp1_rdata_b, out_ram_en_b, out_ram_we_b,
                out_ram_addr_b, out_ram_wdata_b};
    endfunction

    task automatic test_reset();
        in_rst = 1'b1;
        in_req0_valid = 1; in_req0_we = 0; in_req0_addr = 8'h3; in_req0_wdata = 0;
        in_req1_valid = 1; in_req1_we = 0; in_req1_addr = 8'h4; in_req1_wdata = 0;
        @(posedge in_clk); #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (all_outputs() !== 76'h0) begin
                failures++;
                $display("FAIL reset_outputs got=%h exp=0", all_outputs());
            end
            @(posedge in_clk); #1;
        end
        in_rst = 1'b0;
        clear_model();
        cyc = 0;
    endtask

    task automatic test_single_write();
        step(1, 1, 8'h10, 8'hA5, 0, 0, 8'h0, 8'h0);
        checks++;
        if ({r0a, r1a, r0b, r1b} !== 4'b1010) begin
            failures++;
            $display("FAIL wr_ready got=%b exp=1010", {r0a, r1a, r0b, r1b});
        end
        checks++;
        if ({out_ram_en_a, out_ram_we_a, out_ram_addr_a, out_ram_wdata_a} !== 18'h3_10A5) begin
            failures++;
            $display("FAIL wr_ram_cmd got=%h exp=310a5",
                     {out_ram_en_a, out_ram_we_a, out_ram_addr_a, out_ram_wdata_a});
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({out_rsp0_valid_a, out_rsp1_valid_a, out_rsp0_valid_b, out_rsp1_valid_b} !== 4'b0) begin
                failures++;
                $display("FAIL wr_no_rsp cyc=%0d got=%b exp=0000", cyc,
                    {out_rsp0_valid_a, out_rsp1_valid_a, out_rsp0_valid_b, out_rsp1_valid_b});
            end
            idle();
            if (k == 0) begin
                checks++;
                if ({out_ram_en_a, out_ram_we_a} !== 2'b00) begin
                    failures++;
                    $display("FAIL wr_ram_idle got=%b exp=00", {out_ram_en_a, out_ram_we_a});
                end
            end
        end
    endtask

    task automatic test_single_read();
        int t;
        t = cyc;
        step(0, 0, 8'h0, 8'h0, 1, 0, 8'h10, 8'h0);
        checks++;
        if ({r0a, r1a} !== 2'b01) begin
            failures++;
            $display("FAIL rd_ready got=%b exp=01", {r0a, r1a});
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({out_rsp0_valid_a, out_rsp1_valid_a} !== {1'b0, cyc == t + 3}) begin
                failures++;
                $display("FAIL rd_valid cyc=%0d got=%b exp=%b", cyc - t,
                         {out_rsp0_valid_a, out_rsp1_valid_a}, {1'b0, cyc == t + 3});
            end
            if (cyc == t + 3) begin
                checks++;
                if (out_rsp1_rdata_a !== 8'hA5) begin
                    failures++;
                    $display("FAIL rd_data got=%h exp=a5", out_rsp1_rdata_a);
                end
            end
            idle();
        end
    endtask

    task automatic test_reset_pointer();
        do_reset();
        step(1, 0, 8'h20, 8'h0, 1, 0, 8'h21, 8'h0);
        checks++;
        if ({r0a, r1a, r0b, r1b} !== 4'b1010) begin
            failures++;
            $display("FAIL ptr_first got=%b exp=1010", {r0a, r1a, r0b, r1b});
        end
        step(0, 0, 8'h0, 8'h0, 1, 0, 8'h21, 8'h0);
        checks++;
        if ({r0a, r1a} !== 2'b01) begin
            failures++;
            $display("FAIL ptr_second got=%b exp=01", {r0a, r1a});
        end
        for (int k = 0; k < 6; k++) idle();
    endtask

    task automatic test_contention();
        logic [7:0] got0[$], got1[$];
        int i0, i1, first, last, pulses;
        i0 = 0; i1 = 0; first = -1; last = -1; pulses = 0;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (out_rsp0_valid_a) got0.push_back(out_rsp0_rdata_a);
            if (out_rsp1_valid_a) got1.push_back(out_rsp1_rdata_a);
            if (out_rsp0_valid_a || out_rsp1_valid_a) begin
                pulses++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (k < 8) begin
                step(i0 < 4, 0, 8'(i0), 8'h0, i1 < 4, 0, 8'(4 + i1), 8'h0);
                checks++;
                if ({r0a, r1a} !== {k % 2 == 0, k % 2 == 1}) begin
                    failures++;
                    $display("FAIL rr_alt k=%0d got=%b exp=%b", k, {r0a, r1a},
                             {k % 2 == 0, k % 2 == 1});
                end
                if (k % 2 == 0) i0++;
                else i1++;
            end else begin
                idle();
            end
        end
        checks++;
        if (got0.size() != 4 || got1.size() != 4 || pulses != 8 || last - first != 7) begin
            failures++;
            $display("FAIL rr_count got=%0d/%0d/%0d/%0d exp=4/4/8/7",
                     got0.size(), got1.size(), pulses, last - first);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got0[i] !== 8'(8'h40 + i) || got1[i] !== 8'(8'h44 + i)) begin
                    failures++;
                    $display("FAIL rr_data i=%0d got=%h/%h exp=%h/%h", i, got0[i], got1[i],
                             8'(8'h40 + i), 8'(8'h44 + i));
                end
            end
        end
    endtask

    task automatic test_raw_and_lat3();
        int t;
        step(1, 1, 8'h30, 8'h5C, 0, 0, 8'h0, 8'h0);
        t = cyc;
        step(0, 0, 8'h0, 8'h0, 1, 0, 8'h30, 8'h0);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if ({out_rsp1_valid_a, out_rsp1_valid_b, out_rsp0_valid_b} !==
                {cyc == t + 3, cyc == t + 5, 1'b0}) begin
                failures++;
                $display("FAIL raw_valid cyc=%0d got=%b exp=%b", cyc - t,
                         {out_rsp1_valid_a, out_rsp1_valid_b, out_rsp0_valid_b},
                         {cyc == t + 3, cyc == t + 5, 1'b0});
            end
            if (cyc == t + 3 || cyc == t + 5) begin
                checks++;
                if ((cyc == t + 3 ? out_rsp1_rdata_a : out_rsp1_rdata_b) !== 8'h5C) begin
                    failures++;
                    $display("FAIL raw_data cyc=%0d got=%h exp=5c", cyc - t,
                             cyc == t + 3 ? out_rsp1_rdata_a : out_rsp1_rdata_b);
                end
            end
            idle();
        end
    endtask

    task automatic test_reset_midflight();
        step(1, 0, 8'h01, 8'h0, 0, 0, 8'h0, 8'h0);
        step(0, 0, 8'h0, 8'h0, 1, 0, 8'h02, 8'h0);
        in_rst = 1'b1;
        in_req0_valid = 1; in_req1_valid = 1;
        #1;
        checks++;
        if (all_outputs() !== 76'h0) begin
            failures++;
            $display("FAIL mid_rst_outputs got=%h exp=0", all_outputs());
        end
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        clear_model();
        cyc++;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({out_rsp0_valid_a, out_rsp1_valid_a, out_rsp0_valid_b, out_rsp1_valid_b} !== 4'b0) begin
                failures++;
                $display("FAIL mid_no_rsp k=%0d got=%b exp=0000", k,
                    {out_rsp0_valid_a, out_rsp1_valid_a, out_rsp0_valid_b, out_rsp1_valid_b});
            end
            idle();
        end
    endtask

    task automatic test_random();
        logic       pv[2], pw[2];
        logic [7:0] pa[2], pd[2];
        bit         ce;
        pv[0] = 0; pv[1] = 0; pw[0] = 0; pw[1] = 0;
        pa[0] = 0; pa[1] = 0; pd[0] = 0; pd[1] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (n >= 392) pv[r] = 0;
                else if (!pv[r] && $urandom_range(0, 9) < 6) begin
                    pv[r] = 1;
                    pw[r] = ($urandom_range(0, 2) == 0);
                    pa[r] = 8'($urandom_range(0, 15));
                    pd[r] = 8'($urandom);
                end else if (pv[r] && $urandom_range(0, 19) == 0) pv[r] = 0;
            end
            ce = exp_en.exists(cyc) != 0;
            checks++;
            if ({out_ram_en_a, out_ram_en_b} !== {ce, ce}) begin
                failures++;
                $display("FAIL rnd_en cyc=%0d got=%b exp=%b", cyc,
                         {out_ram_en_a, out_ram_en_b}, {ce, ce});
            end
            if (ce) begin
                checks++;
                if ({out_ram_we_a, out_ram_addr_a, out_ram_we_b, out_ram_addr_b} !==
                    {exp_we[cyc], exp_addr[cyc], exp_we[cyc], exp_addr[cyc]} ||
                    (exp_we[cyc] && out_ram_wdata_a !== exp_wd[cyc])) begin
                    failures++;
                    $display("FAIL rnd_cmd cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc,
                             out_ram_we_a, out_ram_addr_a, out_ram_wdata_a,
                             exp_we[cyc], exp_addr[cyc], exp_wd[cyc]);
                end
            end
            checks++;
            if ({out_rsp0_valid_a, out_rsp1_valid_a, out_rsp0_rdata_a, out_rsp1_rdata_a} !==
                {exp_r0a.exists(cyc) != 0, exp_r1a.exists(cyc) != 0, hold0a, hold1a}) begin
                failures++;
                $display("FAIL rnd_rsp_a cyc=%0d got=%b%b/%h/%h exp=%b%b/%h/%h", cyc,
                         out_rsp0_valid_a, out_rsp1_valid_a, out_rsp0_rdata_a, out_rsp1_rdata_a,
                         exp_r0a.exists(cyc) != 0, exp_r1a.exists(cyc) != 0, hold0a, hold1a);
            end
            checks++;
            if ({out_rsp0_valid_b, out_rsp1_valid_b, out_rsp0_rdata_b, out_rsp1_rdata_b} !==
                {exp_r0b.exists(cyc) != 0, exp_r1b.exists(cyc) != 0, hold0b, hold1b}) begin
                failures++;
                $display("FAIL rnd_rsp_b cyc=%0d got=%b%b/%h/%h exp=%b%b/%h/%h", cyc,
                         out_rsp0_valid_b, out_rsp1_valid_b, out_rsp0_rdata_b, out_rsp1_rdata_b,
                         exp_r0b.exists(cyc) != 0, exp_r1b.exists(cyc) != 0, hold0b, hold1b);
            end
            step(pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1]);
            checks++;
            if ({r0a, r1a, r0b, r1b} !== {exp_win == 0, exp_win == 1, exp_win == 0, exp_win == 1}) begin
                failures++;
                $display("FAIL rnd_ready n=%0d got=%b exp_win=%0d", n, {r0a, r1a, r0b, r1b}, exp_win);
            end
            if (exp_win >= 0) pv[exp_win] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i + 64);
        in_rst = 1'b1;
        in_req0_valid = 0; in_req0_we = 0; in_req0_addr = 0; in_req0_wdata = 0;
        in_req1_valid = 0; in_req1_we = 0; in_req1_addr = 0; in_req1_wdata = 0;
        test_reset();
        test_single_write();
        test_single_read();
        test_reset_pointer();
        test_contention();
        test_raw_and_lat3();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
